fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and hazard unit for the pipelined RV32I core. It replaces fixed two-source, two-stage forwarding-select decoding.
- It tracks in-flight register writers in a shift-register scoreboard and detects load-use hazards in ID.
- It issues registered per-source forwarding selects and the bubble/normal control select to EX.
- It handles configurable load latency, flush and whole-pipeline memory freeze.

---
 rtl/fwd_hazard_unit.sv | 95 +++++++++
 tb/tb_fwd_hazard_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: tracks in-flight writers in a shift-register scoreboard,
// detects load-use hazards in ID and issues registered EX forwarding selects.
module fwd_hazard_unit #(
    parameter int NUM_SRC  = 2,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int REG_AW   = 5,
    localparam int SW      = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_we,
    input  logic                      id_is_load,
    input  logic                      flush,
    input  logic                      mem_busy,
    output logic                      id_stall,
    output logic                      ex_ctrl_sel,
    output logic [NUM_SRC*SW-1:0]     fwd_sel,
    output logic [31:0]               stall_cnt
);
    logic              v_q  [NUM_FWD];
    logic              v_d  [NUM_FWD];
    logic [REG_AW-1:0] rd_q [NUM_FWD];
    logic [REG_AW-1:0] rd_d [NUM_FWD];
    logic              ld_q [NUM_FWD];
    logic              ld_d [NUM_FWD];
    logic                  ex_ctrl_q, ex_ctrl_d;
    logic [NUM_SRC*SW-1:0] fwd_q, fwd_d, sel;
    logic [31:0]           cnt_q, cnt_d;
    logic [NUM_SRC-1:0]    src_haz;
    logic                  hazard, kill;

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        sel     = '0;
        src_haz = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (id_valid && id_rs_used[i] && v_q[k] && rd_q[k] != '0 &&
                    rd_q[k] == id_rs[i*REG_AW +: REG_AW]) begin
                    sel[i*SW +: SW] = SW'(k + 1);
                    src_haz[i]      = ld_q[k] && (k < LOAD_LAT);
                end
            end
        end
    end

    assign hazard = |src_haz;
    assign kill   = flush | hazard;
    assign id_stall = hazard & ~flush & ~mem_busy;

    always_comb begin
        v_d[0]  = !kill && id_valid && id_we && id_rd != '0;
        rd_d[0] = id_rd;
        ld_d[0] = id_is_load;
        for (int k = 1; k < NUM_FWD; k++) begin
            v_d[k]  = v_q[k-1];
            rd_d[k] = rd_q[k-1];
            ld_d[k] = ld_q[k-1];
        end
        ex_ctrl_d = !kill && id_valid;
        fwd_d     = kill ? '0 : sel;
        cnt_d     = (hazard && !flush && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                v_q[k]  <= 1'b0;
                rd_q[k] <= '0;
                ld_q[k] <= 1'b0;
            end
            ex_ctrl_q <= 1'b0;
            fwd_q     <= '0;
            cnt_q     <= '0;
        end else if (!mem_busy) begin
            for (int k = 0; k < NUM_FWD; k++) begin
                v_q[k]  <= v_d[k];
                rd_q[k] <= rd_d[k];
                ld_q[k] <= ld_d[k];
            end
            ex_ctrl_q <= ex_ctrl_d;
            fwd_q     <= fwd_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ex_ctrl_sel = ex_ctrl_q;
    assign fwd_sel     = fwd_q;
    assign stall_cnt   = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: drives two configurations (2/1 and 3/2) with shared
// stimulus and scoreboards them against a per-register age model.
module tb_fwd_hazard_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [9:0]  id_rs = '0;
    logic [1:0]  id_rs_used = '0;
    logic [4:0]  id_rd = '0;
    logic        id_we = 1'b0, id_is_load = 1'b0, flush = 1'b0, mem_busy = 1'b0;
    logic        stall_a, stall_b, exc_a, exc_b;
    logic [3:0]  fwd_a, fwd_b;
    logic [31:0] cnt_a, cnt_b;

    typedef struct packed {
        logic [1:0]       stall;
        logic [1:0]       exc;
        logic [1:0][3:0]  fwd;
        logic [1:0][31:0] cnt;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0, n_err = 0;
    int          age[2][32];
    bit          isld[2][32];
    logic        mexc[2];
    logic [3:0]  mfwd[2];
    logic [31:0] mcnt[2];
    int          nf[2] = '{2, 3};
    int          ll[2] = '{1, 2};

    always #5 clk = ~clk;

    fwd_hazard_unit u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .mem_busy(mem_busy),
        .id_stall(stall_a), .ex_ctrl_sel(exc_a), .fwd_sel(fwd_a), .stall_cnt(cnt_a));

    fwd_hazard_unit #(.NUM_FWD(3), .LOAD_LAT(2)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .flush(flush), .mem_busy(mem_busy),
        .id_stall(stall_b), .ex_ctrl_sel(exc_b), .fwd_sel(fwd_b), .stall_cnt(cnt_b));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 32; r++) begin
                age[c][r]  = 99;
                isld[c][r] = 1'b0;
            end
            mexc[c] = 1'b0;
            mfwd[c] = '0;
            mcnt[c] = '0;
        end
    endtask

    // age[c][r] = cycles since the most recent writer of r entered EX.
    task automatic step(output exp_t e);
        for (int c = 0; c < 2; c++) begin
            logic [3:0] s = '0;
            bit hz = 1'b0, kill;
            for (int i = 0; i < 2; i++) begin
                int r = int'(id_rs[i*5 +: 5]);
                if (id_valid && id_rs_used[i] && r != 0 && age[c][r] < nf[c]) begin
                    s[i*2 +: 2] = 2'(age[c][r] + 1);
                    if (isld[c][r] && age[c][r] < ll[c]) hz = 1'b1;
                end
            end
            kill = flush || hz;
            e.stall[c] = hz && !flush && !mem_busy;
            if (!mem_busy) begin
                for (int r = 0; r < 32; r++) if (age[c][r] < 99) age[c][r]++;
                if (!kill && id_valid && id_we && id_rd != 0) begin
                    age[c][id_rd]  = 0;
                    isld[c][id_rd] = id_is_load;
                end
                mexc[c] = !kill && id_valid;
                mfwd[c] = kill ? 4'd0 : s;
                if (hz && !flush && mcnt[c] != '1) mcnt[c]++;
            end
            e.exc[c] = mexc[c];
            e.fwd[c] = mfwd[c];
            e.cnt[c] = mcnt[c];
        end
    endtask

    task automatic issue(input logic v, input logic [4:0] r0, r1, input logic [1:0] u,
                         input logic [4:0] d, input logic w, l, f, b, output logic stalled);
        exp_t e;
        @(negedge clk);
        id_valid = v; id_rs = {r1, r0}; id_rs_used = u; id_rd = d;
        id_we = w; id_is_load = l; flush = f; mem_busy = b;
        step(e);
        sbq.push_back(e);
        stalled = |e.stall;
    endtask

    task automatic instr(input logic v, input logic [4:0] r0, r1, input logic [1:0] u,
                         input logic [4:0] d, input logic w, l);
        logic st;
        int n = 0;
        do begin
            issue(v, r0, r1, u, d, w, l, 1'b0, 1'b0, st);
            n++;
        end while (st && n < 8);
    endtask

    // Monitor: id_stall sampled just before the edge, registered outputs just after it.
    initial begin
        logic [1:0] st;
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sbq.size() > 0) begin
                st = {stall_b, stall_a};
                @(posedge clk);
                #1;
                e = sbq.pop_front();
                chk("stall_a", st[0], e.stall[0]);
                chk("stall_b", st[1], e.stall[1]);
                chk("exc_a", exc_a, e.exc[0]);
                chk("exc_b", exc_b, e.exc[1]);
                chk("fwd_a", fwd_a, e.fwd[0]);
                chk("fwd_b", fwd_b, e.fwd[1]);
                chk("cnt_a", cnt_a, e.cnt[0]);
                chk("cnt_b", cnt_b, e.cnt[1]);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_stall_a"}, stall_a, 0); chk({tag, "_stall_b"}, stall_b, 0);
        chk({tag, "_exc_a"}, exc_a, 0);     chk({tag, "_exc_b"}, exc_b, 0);
        chk({tag, "_fwd_a"}, fwd_a, 0);     chk({tag, "_fwd_b"}, fwd_b, 0);
        chk({tag, "_cnt_a"}, cnt_a, 0);     chk({tag, "_cnt_b"}, cnt_b, 0);
    endtask

    initial begin
        logic st, hold;
        logic v, w, l, f, b;
        logic [4:0] r0, r1, d;
        logic [1:0] u;
        #1 rst = 1'b0;
        model_reset();
        #12 chk_zero("reset");
        @(negedge clk) rst = 1'b1;
        // dependent ALU pair, then load-use
        instr(1, 0, 0, 0, 5, 1, 0);
        instr(1, 5, 7, 3, 6, 1, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        instr(1, 0, 0, 0, 5, 1, 1);
        instr(1, 5, 5, 3, 6, 1, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        // youngest writer wins; x0 never forwards
        instr(1, 0, 0, 0, 5, 1, 0);
        instr(1, 0, 0, 0, 5, 1, 0);
        instr(1, 5, 0, 1, 8, 1, 0);
        instr(1, 0, 0, 0, 0, 1, 1);
        instr(1, 0, 0, 1, 9, 1, 0);
        // load with and without an independent instruction in between
        instr(1, 0, 0, 0, 3, 1, 1);
        instr(1, 3, 0, 1, 4, 1, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        instr(1, 0, 0, 0, 3, 1, 1);
        instr(1, 1, 2, 3, 10, 1, 0);
        instr(1, 0, 3, 2, 4, 1, 0);
        // memory freeze across a load-use, then flush during a hazard
        instr(1, 0, 0, 0, 5, 1, 1);
        repeat (3) issue(1, 5, 0, 1, 6, 1, 0, 0, 1, st);
        instr(1, 5, 0, 1, 6, 1, 0);
        instr(1, 0, 0, 0, 7, 1, 1);
        issue(1, 7, 0, 1, 8, 1, 0, 1, 0, st);
        instr(0, 0, 0, 0, 0, 0, 0);
        // randomized traffic with stalls and freezes held at the source
        hold = 0; f = 0; b = 0;
        {v, r0, r1, u, d, w, l} = '0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                v  = ($urandom_range(0, 7) != 0);
                r0 = 5'($urandom_range(0, 7));
                r1 = 5'($urandom_range(0, 7));
                u  = 2'($urandom);
                d  = 5'($urandom_range(0, 7));
                w  = ($urandom_range(0, 3) != 0);
                l  = ($urandom_range(0, 2) == 0);
            end
            if (!b) f = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 5) == 0);
            issue(v, r0, r1, u, d, w, l, f, b, st);
            hold = (st || b) && !f;
        end
        instr(0, 0, 0, 0, 0, 0, 0);
        // reset asserted mid-stall
        instr(1, 0, 0, 0, 9, 1, 1);
        issue(1, 9, 9, 3, 11, 1, 0, 0, 0, st);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_zero("mid_rst");
        model_reset();
        @(negedge clk) rst = 1'b1;
        instr(1, 9, 9, 3, 11, 1, 0);
        instr(0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2 chk("drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
